// File: rtl/o_buf_reader.sv
// rtl/o_buf_reader.sv - linebuffer read controller: fetches 32-bit words, streams 8-bit pixels with sol/eol
// Optional O_BUF_PREFETCH_EN adds a one-word prefetch register for 1 px/cycle sustained throughput.
module o_buf_reader #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WORDS = 160
) (
  input  logic                  pclk,
  input  logic                  reset_n,
  input  logic                  line_valid,
  input  logic [ADDR_WIDTH-1:0] line_base,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [31:0]           rd_data,
  output logic [7:0]            px_data,
  output logic                  px_valid,
  input  logic                  px_ready,
  output logic                  px_sol,
  output logic                  px_eol,
  output logic                  busy,
  output logic                  overrun
);

  localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, SHIFT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
  logic [1:0]            lane_q, lane_d;
  logic [31:0]           shreg_q, shreg_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]            px_data_q, px_data_d;
  logic                  px_valid_q, px_valid_d;
  logic                  px_sol_q, px_sol_d;
  logic                  px_eol_q, px_eol_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

  logic                  transfer;
  logic [1:0]            lane_nx;
  logic [CNT_W-1:0]      cnt_nx;

`ifdef O_BUF_PREFETCH_EN
  logic [31:0]           pf_q, pf_d;
  logic                  pf_valid_q, pf_valid_d;
  logic                  pf_rd_q, pf_rd_d;
  logic                  pf_wait_q, pf_wait_d;
  logic [CNT_W-1:0]      cnt_nx2;
`endif

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    word_cnt_d = word_cnt_q;
    lane_d     = lane_q;
    shreg_d    = shreg_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    px_data_d  = px_data_q;
    px_valid_d = px_valid_q;
    px_sol_d   = px_sol_q;
    px_eol_d   = px_eol_q;
    transfer   = px_valid_q & px_ready;
    lane_nx    = lane_q + 2'd1;
    cnt_nx     = word_cnt_q + CNT_W'(1);
    overrun_d  = line_valid & (state_q != IDLE);
`ifdef O_BUF_PREFETCH_EN
    cnt_nx2    = cnt_nx + CNT_W'(1);
    pf_d       = pf_q;
    pf_valid_d = pf_valid_q;
    pf_rd_d    = 1'b0;
    pf_wait_d  = rd_en_q & pf_rd_q;
    // Prefetch data lands one cycle after its strobe, independent of FSM state.
    if (pf_wait_q) begin
      pf_d       = rd_data;
      pf_valid_d = 1'b1;
    end
`endif
    case (state_q)
      IDLE: begin
        if (line_valid) begin
          base_d     = line_base;
          word_cnt_d = '0;
          rd_en_d    = 1'b1;
          rd_addr_d  = line_base;
          state_d    = REQ;
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        shreg_d    = rd_data;
        lane_d     = 2'd0;
        px_valid_d = 1'b1;
        px_data_d  = rd_data[7:0];
        px_sol_d   = (word_cnt_q == '0);
        px_eol_d   = 1'b0;
        state_d    = SHIFT;
`ifdef O_BUF_PREFETCH_EN
        if (word_cnt_q != LAST_WORD) begin
          rd_en_d   = 1'b1;
          pf_rd_d   = 1'b1;
          rd_addr_d = base_q + ADDR_WIDTH'(cnt_nx);
        end
`endif
      end
      SHIFT: begin
        if (transfer) begin
          px_sol_d = 1'b0;
          px_eol_d = 1'b0;
          if (lane_q == 2'd3) begin
            px_valid_d = 1'b0;
            if (word_cnt_q == LAST_WORD) begin
              state_d = IDLE;
            end
`ifdef O_BUF_PREFETCH_EN
            else if (pf_valid_q) begin
              word_cnt_d = cnt_nx;
              shreg_d    = pf_q;
              lane_d     = 2'd0;
              px_valid_d = 1'b1;
              px_data_d  = pf_q[7:0];
              pf_valid_d = 1'b0;
              if (cnt_nx != LAST_WORD) begin
                rd_en_d   = 1'b1;
                pf_rd_d   = 1'b1;
                rd_addr_d = base_q + ADDR_WIDTH'(cnt_nx2);
              end
            end
`endif
            else begin
              word_cnt_d = cnt_nx;
              rd_en_d    = 1'b1;
              rd_addr_d  = base_q + ADDR_WIDTH'(cnt_nx);
              state_d    = REQ;
            end
          end else begin
            lane_d    = lane_nx;
            px_data_d = shreg_q[{lane_nx, 3'b000} +: 8];
            px_eol_d  = (lane_nx == 2'd3) && (word_cnt_q == LAST_WORD);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      word_cnt_q <= '0;
      lane_q     <= '0;
      shreg_q    <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      px_data_q  <= '0;
      px_valid_q <= 1'b0;
      px_sol_q   <= 1'b0;
      px_eol_q   <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef O_BUF_PREFETCH_EN
      pf_q       <= '0;
      pf_valid_q <= 1'b0;
      pf_rd_q    <= 1'b0;
      pf_wait_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      word_cnt_q <= word_cnt_d;
      lane_q     <= lane_d;
      shreg_q    <= shreg_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      px_data_q  <= px_data_d;
      px_valid_q <= px_valid_d;
      px_sol_q   <= px_sol_d;
      px_eol_q   <= px_eol_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
`ifdef O_BUF_PREFETCH_EN
      pf_q       <= pf_d;
      pf_valid_q <= pf_valid_d;
      pf_rd_q    <= pf_rd_d;
      pf_wait_q  <= pf_wait_d;
`endif
    end
  end

  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign px_data  = px_data_q;
  assign px_valid = px_valid_q;
  assign px_sol   = px_sol_q;
  assign px_eol   = px_eol_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_o_buf_reader.sv
// tb/tb_o_buf_reader.sv - scoreboard bench for o_buf_reader with a one-cycle-latency linebuffer model
module tb_o_buf_reader;

  localparam int LW = 2;

  logic        pclk = 1'b0;
  logic        reset_n;
  logic        line_valid;
  logic [15:0] line_base;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [31:0] rd_data = '0;
  logic [7:0]  px_data;
  logic        px_valid;
  logic        px_ready;
  logic        px_sol;
  logic        px_eol;
  logic        busy;
  logic        overrun;

  logic [31:0] mem [0:65535];

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  exp_px[$], obs_px[$];
  logic [1:0]  exp_mk[$], obs_mk[$];
  logic [15:0] exp_addr[$], obs_addr[$];
  int          exp_gap[$];
  int          obs_cyc[$], obs_ov[$];
  logic        busy_at[$];
  logic [9:0]  obs_stall[$];

  o_buf_reader #(.ADDR_WIDTH(16), .LINE_WORDS(LW)) dut (
    .pclk(pclk), .reset_n(reset_n), .line_valid(line_valid), .line_base(line_base),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
    .px_sol(px_sol), .px_eol(px_eol), .busy(busy), .overrun(overrun)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic push_line(input logic [15:0] base);
    logic [15:0] a;
    logic [31:0] w;
    for (int i = 0; i < LW; i++) begin
      a = base + 16'(i);
      w = mem[a];
      exp_addr.push_back(a);
      for (int l = 0; l < 4; l++) begin
        exp_px.push_back(w[8*l +: 8]);
        exp_mk.push_back({(i == 0 && l == 0), (i == LW - 1 && l == 3)});
      end
    end
  endtask

  task automatic collect(input int ncyc, input logic [7:0] stall_px, input int stall_len,
                         input int lv_a, input logic [15:0] base_a,
                         input int lv_b, input logic [15:0] base_b, input bit lv_eol);
    int stall_left;
    bit stall_done;
    stall_left = 0;
    stall_done = 0;
    obs_px.delete(); obs_mk.delete(); obs_addr.delete(); obs_cyc.delete();
    obs_ov.delete(); busy_at.delete(); obs_stall.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge pclk);
      if (stall_left > 0) begin
        px_ready = 1'b0;
        stall_left--;
      end else if (stall_len > 0 && !stall_done && px_valid && px_data == stall_px) begin
        px_ready = 1'b0;
        stall_done = 1;
        stall_left = stall_len - 1;
      end else begin
        px_ready = 1'b1;
      end
      line_valid = 1'b0;
      if (c == lv_a) begin line_valid = 1'b1; line_base = base_a; end
      if (c == lv_b) begin line_valid = 1'b1; line_base = base_b; end
      if (lv_eol && px_valid && px_ready && px_eol) line_valid = 1'b1;
      if (!px_ready) obs_stall.push_back({px_valid, px_data, rd_en});
      if (px_valid && px_ready) begin
        obs_px.push_back(px_data);
        obs_mk.push_back({px_sol, px_eol});
        obs_cyc.push_back(c);
      end
      if (rd_en) obs_addr.push_back(rd_addr);
      if (overrun) obs_ov.push_back(c);
      busy_at.push_back(busy);
    end
    line_valid = 1'b0;
    px_ready   = 1'b1;
  endtask

  task automatic test_reset();
    bit got;
    @(negedge pclk);
    n_cmp++;
    if ({rd_en, rd_addr, px_data, px_valid, px_sol, px_eol, busy, overrun} !== 30'd0) begin
      n_err++;
      $display("FAIL reset_outputs got %h want 0", {rd_en, rd_addr, px_data, px_valid, px_sol, px_eol, busy, overrun});
    end
    reset_n = 1'b1;
    @(negedge pclk);
    line_valid = 1'b1; line_base = 16'h0010;
    @(negedge pclk);
    line_valid = 1'b0;
    n_cmp++;
    if (rd_en !== 1'b1) begin n_err++; $display("FAIL reset_req_rd_en got %b want 1", rd_en); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({rd_en, busy} !== 2'b00) begin n_err++; $display("FAIL reset_async_req got rd_en/busy %b want 00", {rd_en, busy}); end
    @(negedge pclk);
    reset_n = 1'b1;
    @(negedge pclk);
    line_valid = 1'b1; line_base = 16'h0010;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge pclk);
      line_valid = 1'b0;
      got = px_valid;
    end
    n_cmp++;
    if (got !== 1'b1) begin n_err++; $display("FAIL reset_px_valid_timeout got %b want 1", got); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({px_valid, rd_en} !== 2'b00) begin n_err++; $display("FAIL reset_async_shift got px_valid/rd_en %b want 00", {px_valid, rd_en}); end
    @(negedge pclk);
    reset_n = 1'b1;
    collect(20, 8'h00, 0, -1, 16'h0, -1, 16'h0, 0);
    n_cmp++;
    if (obs_px.size() + obs_addr.size() != 0) begin
      n_err++; $display("FAIL reset_after_release got %0d px %0d reads want 0", obs_px.size(), obs_addr.size());
    end
  endtask

  task automatic test_basic();
    logic [7:0] e, o;
    logic [1:0] em, om;
    int ec;
    push_line(16'h0010);
    collect(40, 8'h00, 0, 0, 16'h0010, -1, 16'h0, 0);
    n_cmp++;
    if (obs_px.size() != 8) begin n_err++; $display("FAIL basic_count got %0d want 8", obs_px.size()); end
    n_cmp++;
    if (obs_cyc.size() == 0 || obs_cyc[0] != 3) begin n_err++; $display("FAIL basic_latency got %0d want 3", obs_cyc.size() ? obs_cyc[0] : -1); end
    n_cmp++;
    ec = obs_cyc.size() ? obs_cyc[obs_cyc.size()-1] : 0;
    if (ec == 0 || busy_at[ec] !== 1'b1 || busy_at[ec+1] !== 1'b0) begin
      n_err++; $display("FAIL basic_busy_end got %b%b want 10", busy_at[ec], busy_at[ec+1]);
    end
    while (exp_addr.size() != 0) begin
      n_cmp++;
      if (obs_addr.size() == 0) begin n_err++; $display("FAIL basic_addr missing want %h", exp_addr.pop_front()); end
      else if (obs_addr[0] !== exp_addr[0]) begin n_err++; $display("FAIL basic_addr got %h want %h", obs_addr.pop_front(), exp_addr.pop_front()); end
      else begin void'(obs_addr.pop_front()); void'(exp_addr.pop_front()); end
    end
    while (exp_px.size() != 0) begin
      e = exp_px.pop_front(); em = exp_mk.pop_front();
      n_cmp++;
      if (obs_px.size() == 0) begin n_err++; $display("FAIL basic_px missing want %h", e); end
      else begin
        o = obs_px.pop_front(); om = obs_mk.pop_front();
        if ({o, om} !== {e, em}) begin n_err++; $display("FAIL basic_px got %h sol/eol %b want %h %b", o, om, e, em); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] e, o;
    logic [1:0] em, om;
    push_line(16'h0010);
    exp_addr.delete();
    collect(40, 8'h33, 3, 0, 16'h0010, -1, 16'h0, 0);
    n_cmp++;
    if (obs_stall.size() != 3) begin n_err++; $display("FAIL bp_stall_len got %0d want 3", obs_stall.size()); end
    while (obs_stall.size() != 0) begin
      n_cmp++;
      if (obs_stall[0] !== {1'b1, 8'h33, 1'b0}) begin n_err++; $display("FAIL bp_hold got valid/data/rd_en %h want 266", obs_stall[0]); end
      void'(obs_stall.pop_front());
    end
    n_cmp++;
    if (obs_addr.size() != 2) begin n_err++; $display("FAIL bp_reads got %0d want 2", obs_addr.size()); end
    while (exp_px.size() != 0) begin
      e = exp_px.pop_front(); em = exp_mk.pop_front();
      n_cmp++;
      if (obs_px.size() == 0) begin n_err++; $display("FAIL bp_px missing want %h", e); end
      else begin
        o = obs_px.pop_front(); om = obs_mk.pop_front();
        if ({o, om} !== {e, em}) begin n_err++; $display("FAIL bp_px got %h sol/eol %b want %h %b", o, om, e, em); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] e, o;
    logic [1:0] em, om;
    push_line(16'hFFFF);
    collect(40, 8'h00, 0, 0, 16'hFFFF, -1, 16'h0, 0);
    while (exp_addr.size() != 0) begin
      n_cmp++;
      if (obs_addr.size() == 0) begin n_err++; $display("FAIL wrap_addr missing want %h", exp_addr.pop_front()); end
      else if (obs_addr[0] !== exp_addr[0]) begin n_err++; $display("FAIL wrap_addr got %h want %h", obs_addr.pop_front(), exp_addr.pop_front()); end
      else begin void'(obs_addr.pop_front()); void'(exp_addr.pop_front()); end
    end
    while (exp_px.size() != 0) begin
      e = exp_px.pop_front(); em = exp_mk.pop_front();
      n_cmp++;
      if (obs_px.size() == 0) begin n_err++; $display("FAIL wrap_px missing want %h", e); end
      else begin
        o = obs_px.pop_front(); om = obs_mk.pop_front();
        if ({o, om} !== {e, em}) begin n_err++; $display("FAIL wrap_px got %h sol/eol %b want %h %b", o, om, e, em); end
      end
    end
  endtask

  task automatic test_overrun();
    int ec;
    collect(40, 8'h00, 0, 0, 16'h0010, 5, 16'h0040, 1);
    ec = obs_cyc.size() ? obs_cyc[obs_cyc.size()-1] : -10;
    n_cmp++;
    if (obs_px.size() != 8) begin n_err++; $display("FAIL ov_count got %0d want 8", obs_px.size()); end
    n_cmp++;
    if (obs_ov.size() != 2) begin n_err++; $display("FAIL ov_pulses got %0d want 2", obs_ov.size()); end
    else begin
      n_cmp++;
      if (obs_ov[0] != 6) begin n_err++; $display("FAIL ov_busy_pulse got cycle %0d want 6", obs_ov[0]); end
      n_cmp++;
      if (obs_ov[1] != ec + 1) begin n_err++; $display("FAIL ov_eol_pulse got cycle %0d want %0d", obs_ov[1], ec + 1); end
    end
    n_cmp++;
    if (busy_at[39] !== 1'b0) begin n_err++; $display("FAIL ov_busy_idle got %b want 0", busy_at[39]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e, o;
    logic [1:0] em, om;
    push_line(16'h0010);
    push_line(16'h0020);
    exp_addr.delete();
    collect(50, 8'h00, 0, 0, 16'h0010, 13, 16'h0020, 0);
    n_cmp++;
    if (obs_ov.size() != 0) begin n_err++; $display("FAIL b2b_overrun got %0d want 0", obs_ov.size()); end
    n_cmp++;
    if (obs_addr.size() != 4 || obs_addr[2] !== 16'h0020) begin n_err++; $display("FAIL b2b_reads got %0d want 4", obs_addr.size()); end
    while (exp_px.size() != 0) begin
      e = exp_px.pop_front(); em = exp_mk.pop_front();
      n_cmp++;
      if (obs_px.size() == 0) begin n_err++; $display("FAIL b2b_px missing want %h", e); end
      else begin
        o = obs_px.pop_front(); om = obs_mk.pop_front();
        if ({o, om} !== {e, em}) begin n_err++; $display("FAIL b2b_px got %h sol/eol %b want %h %b", o, om, e, em); end
      end
    end
  endtask

  task automatic test_throughput();
    for (int i = 1; i < 8; i++) begin
`ifdef O_BUF_PREFETCH_EN
      exp_gap.push_back(1);
`else
      exp_gap.push_back(i == 4 ? 3 : 1);
`endif
    end
    collect(40, 8'h00, 0, 0, 16'h0010, -1, 16'h0, 0);
    n_cmp++;
    if (obs_cyc.size() != 8) begin
      n_err++; $display("FAIL tp_count got %0d want 8", obs_cyc.size());
      exp_gap.delete();
    end
    for (int i = 1; exp_gap.size() != 0; i++) begin
      n_cmp++;
      if (obs_cyc[i] - obs_cyc[i-1] != exp_gap[0]) begin
        n_err++; $display("FAIL tp_gap%0d got %0d want %0d", i, obs_cyc[i] - obs_cyc[i-1], exp_gap[0]);
      end
      void'(exp_gap.pop_front());
    end
  endtask

  initial begin
    reset_n = 1'b0;
    line_valid = 1'b0;
    line_base = '0;
    px_ready = 1'b1;
    mem[16'h0010] = 32'h44332211;
    mem[16'h0011] = 32'h88776655;
    mem[16'h0020] = 32'hA3A2A1A0;
    mem[16'h0021] = 32'hB7B6B5B4;
    mem[16'hFFFF] = 32'hDDCCBBAA;
    mem[16'h0000] = 32'h04030201;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_overrun();
    test_back_to_back();
    test_throughput();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
